// File: rtl/tpu_pkg.sv
// Shared definitions for the TPU tile scheduler: FSM state encoding,
// array tile geometry and default bus widths.
package tpu_pkg;

  // Edge length of the square systolic array (output tile is TILE_DIM x TILE_DIM).
  localparam int TILE_DIM = 4;

  // Default widths of global-buffer indices and matrix dimensions.
  localparam int ADDR_BITS_DEF = 16;
  localparam int DIM_BITS_DEF  = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_FEED  = 3'd2,
    ST_WAIT  = 3'd3,
    ST_WB    = 3'd4,
    ST_DONE  = 3'd5
  } sched_state_e;

endpackage

// File: rtl/tpu_tile_scheduler_if.sv
// Control/stream bundle between the TPU controller and the tile scheduler.
// master = controller / array side, slave = scheduler.
interface tpu_tile_scheduler_if #(
  parameter int ADDR_BITS = tpu_pkg::ADDR_BITS_DEF,
  parameter int DIM_BITS  = tpu_pkg::DIM_BITS_DEF
);
  logic                 in_valid;
  logic [DIM_BITS-1:0]  K;
  logic [DIM_BITS-1:0]  M;
  logic [DIM_BITS-1:0]  N;
  logic                 busy;
  logic                 done;
  logic                 sa_clear;
  logic                 feed_valid;
  logic [ADDR_BITS-1:0] a_index;
  logic [ADDR_BITS-1:0] b_index;
  logic                 sa_done;
  logic                 wb_en;
  logic [1:0]           wb_row;
  logic [ADDR_BITS-1:0] wb_index;
  logic [31:0]          perf_cycles;

  modport master (
    output in_valid, K, M, N, sa_done,
    input  busy, done, sa_clear, feed_valid, a_index, b_index,
           wb_en, wb_row, wb_index, perf_cycles
  );

  modport slave (
    input  in_valid, K, M, N, sa_done,
    output busy, done, sa_clear, feed_valid, a_index, b_index,
           wb_en, wb_row, wb_index, perf_cycles
  );
endinterface

// File: rtl/tile_index_gen.sv
// Tile/word/row counters and global-buffer index generation.
// All products (mt*K, nt*K, row*NT) are built with running adders so the
// datapath contains no multipliers.
module tile_index_gen
  import tpu_pkg::*;
#(
  parameter int ADDR_BITS = ADDR_BITS_DEF,
  parameter int DIM_BITS  = DIM_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 accept_i,
  input  logic [DIM_BITS-1:0]  k_dim_i,
  input  logic [DIM_BITS-1:0]  m_dim_i,
  input  logic [DIM_BITS-1:0]  n_dim_i,
  input  logic                 feed_step_i,
  input  logic                 wb_step_i,
  output logic                 k_last_o,
  output logic                 r_last_o,
  output logic                 tile_last_o,
  output logic                 row_valid_o,
  output logic [ADDR_BITS-1:0] a_index_o,
  output logic [ADDR_BITS-1:0] b_index_o,
  output logic [ADDR_BITS-1:0] wb_index_o,
  output logic [1:0]           wb_row_o
);

  // Tile counts fit in one bit less than the dimension: ceil((2^D-1)/4) = 2^(D-2).
  localparam int TW = DIM_BITS - 1;

  // ceil(d / TILE_DIM) with TILE_DIM = 4, done as add-and-shift.
  function automatic logic [TW-1:0] tile_count(input logic [DIM_BITS-1:0] d);
    logic [DIM_BITS:0] s;
    s = {1'b0, d} + (DIM_BITS+1)'(TILE_DIM - 1);
    return s[DIM_BITS:2];
  endfunction

  logic [DIM_BITS-1:0]  k_dim_q, k_dim_d;
  logic [DIM_BITS-1:0]  m_dim_q, m_dim_d;
  logic [TW-1:0]        mt_cnt_q, mt_cnt_d;
  logic [TW-1:0]        nt_cnt_q, nt_cnt_d;
  logic [TW-1:0]        mt_q, mt_d;
  logic [TW-1:0]        nt_q, nt_d;
  logic [DIM_BITS-1:0]  k_q, k_d;
  logic [1:0]           r_q, r_d;
  logic [ADDR_BITS-1:0] a_base_q, a_base_d;   // mt*K
  logic [ADDR_BITS-1:0] b_base_q, b_base_d;   // nt*K
  logic [ADDR_BITS-1:0] c_tile_q, c_tile_d;   // (mt*4)*NT + nt, row 0 of the tile
  logic [ADDR_BITS-1:0] wb_acc_q, wb_acc_d;   // (mt*4+r)*NT + nt, current row

  logic [ADDR_BITS-1:0] k_ext;
  logic [ADDR_BITS-1:0] nt_stride;

  assign k_ext     = ADDR_BITS'(k_dim_q);
  assign nt_stride = ADDR_BITS'(nt_cnt_q);

  assign k_last_o    = (k_q == k_dim_q - DIM_BITS'(1));
  assign r_last_o    = (r_q == 2'(TILE_DIM - 1));
  assign tile_last_o = (mt_q == mt_cnt_q - TW'(1)) && (nt_q == nt_cnt_q - TW'(1));
  // {mt, r} is mt*4 + r, the absolute output row of the current write-back.
  assign row_valid_o = ({mt_q, r_q} < {1'b0, m_dim_q});

  assign a_index_o  = a_base_q + ADDR_BITS'(k_q);
  assign b_index_o  = b_base_q + ADDR_BITS'(k_q);
  assign wb_index_o = wb_acc_q;
  assign wb_row_o   = r_q;

  // Next-state for counters and running base adders.
  always_comb begin
    k_dim_d  = k_dim_q;
    m_dim_d  = m_dim_q;
    mt_cnt_d = mt_cnt_q;
    nt_cnt_d = nt_cnt_q;
    mt_d     = mt_q;
    nt_d     = nt_q;
    k_d      = k_q;
    r_d      = r_q;
    a_base_d = a_base_q;
    b_base_d = b_base_q;
    c_tile_d = c_tile_q;
    wb_acc_d = wb_acc_q;

    if (accept_i) begin
      k_dim_d  = k_dim_i;
      m_dim_d  = m_dim_i;
      mt_cnt_d = tile_count(m_dim_i);
      nt_cnt_d = tile_count(n_dim_i);
      mt_d     = '0;
      nt_d     = '0;
      k_d      = '0;
      r_d      = '0;
      a_base_d = '0;
      b_base_d = '0;
      c_tile_d = '0;
      wb_acc_d = '0;
    end else begin
      if (feed_step_i) begin
        k_d = k_last_o ? '0 : k_q + DIM_BITS'(1);
      end
      if (wb_step_i) begin
        r_d      = r_q + 2'd1;
        wb_acc_d = wb_acc_q + nt_stride;
        if (r_last_o) begin
          if (nt_q == nt_cnt_q - TW'(1)) begin
            // Row wrap: on the last row wb_acc already equals c_tile + 3*NT,
            // so the next tile row base (mt+1)*4*NT is just one past it.
            nt_d     = '0;
            mt_d     = mt_q + TW'(1);
            b_base_d = '0;
            a_base_d = a_base_q + k_ext;
            c_tile_d = wb_acc_q + ADDR_BITS'(1);
          end else begin
            nt_d     = nt_q + TW'(1);
            b_base_d = b_base_q + k_ext;
            c_tile_d = c_tile_q + ADDR_BITS'(1);
          end
          wb_acc_d = c_tile_d;
        end
      end
    end
  end

  // Counter and base registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_dim_q  <= '0;
      m_dim_q  <= '0;
      mt_cnt_q <= '0;
      nt_cnt_q <= '0;
      mt_q     <= '0;
      nt_q     <= '0;
      k_q      <= '0;
      r_q      <= '0;
      a_base_q <= '0;
      b_base_q <= '0;
      c_tile_q <= '0;
      wb_acc_q <= '0;
    end else begin
      k_dim_q  <= k_dim_d;
      m_dim_q  <= m_dim_d;
      mt_cnt_q <= mt_cnt_d;
      nt_cnt_q <= nt_cnt_d;
      mt_q     <= mt_d;
      nt_q     <= nt_d;
      k_q      <= k_d;
      r_q      <= r_d;
      a_base_q <= a_base_d;
      b_base_q <= b_base_d;
      c_tile_q <= c_tile_d;
      wb_acc_q <= wb_acc_d;
    end
  end

endmodule

// File: rtl/tpu_tile_scheduler.sv
// Tile scheduler top: walks output tiles (mt outer, nt inner), streams A/B
// words to the 4x4 array and sequences C write-back.
// Optional busy-cycle counter enabled by defining TILE_SCHED_PERF_EN;
// without it perf_cycles is tied to 0.
module tpu_tile_scheduler
  import tpu_pkg::*;
#(
  parameter int ADDR_BITS = ADDR_BITS_DEF,
  parameter int DIM_BITS  = DIM_BITS_DEF
) (
  input logic                 clk,
  input logic                 rst_n,
  tpu_tile_scheduler_if.slave bus
);

  sched_state_e state_q, state_d;

  logic accept;
  logic feed_step;
  logic wb_step;
  logic sa_clear;
  logic feed_valid;
  logic wb_en;
  logic done;
  logic busy;
  logic dims_zero;

  logic k_last;
  logic r_last;
  logic tile_last;
  logic row_valid;

  assign dims_zero = (bus.K == '0) || (bus.M == '0) || (bus.N == '0);
  assign busy      = (state_q != ST_IDLE);

  tile_index_gen #(
    .ADDR_BITS (ADDR_BITS),
    .DIM_BITS  (DIM_BITS)
  ) u_index_gen (
    .clk         (clk),
    .rst_n       (rst_n),
    .accept_i    (accept),
    .k_dim_i     (bus.K),
    .m_dim_i     (bus.M),
    .n_dim_i     (bus.N),
    .feed_step_i (feed_step),
    .wb_step_i   (wb_step),
    .k_last_o    (k_last),
    .r_last_o    (r_last),
    .tile_last_o (tile_last),
    .row_valid_o (row_valid),
    .a_index_o   (bus.a_index),
    .b_index_o   (bus.b_index),
    .wb_index_o  (bus.wb_index),
    .wb_row_o    (bus.wb_row)
  );

  // FSM next-state and state-decoded strobes.
  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    feed_step  = 1'b0;
    wb_step    = 1'b0;
    sa_clear   = 1'b0;
    feed_valid = 1'b0;
    wb_en      = 1'b0;
    done       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          accept  = 1'b1;
          state_d = dims_zero ? ST_DONE : ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        sa_clear = 1'b1;
        state_d  = ST_FEED;
      end
      ST_FEED: begin
        feed_valid = 1'b1;
        feed_step  = 1'b1;
        if (k_last) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.sa_done) state_d = ST_WB;
      end
      ST_WB: begin
        // Rows beyond M still take their slot; only the strobe is suppressed.
        wb_en   = row_valid;
        wb_step = 1'b1;
        if (r_last) state_d = tile_last ? ST_DONE : ST_CLEAR;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.sa_clear   = sa_clear;
  assign bus.feed_valid = feed_valid;
  assign bus.wb_en      = wb_en;

`ifdef TILE_SCHED_PERF_EN
  logic [31:0] perf_q, perf_d;

  // Busy-cycle counter: cleared on accept, saturating, held while idle.
  always_comb begin
    perf_d = perf_q;
    if (accept)                      perf_d = '0;
    else if (busy && (perf_q != '1)) perf_d = perf_q + 32'd1;
  end

  // Perf counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) perf_q <= '0;
    else        perf_q <= perf_d;
  end

  assign bus.perf_cycles = perf_q;
`else
  assign bus.perf_cycles = '0;
`endif

endmodule
